// File: rtl/result_uart_tx_if.sv
// Control and result-BRAM read signals between the host command logic and result_uart_tx.
interface result_uart_tx_if #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 16
);
  logic                  start;
  logic [ADDR_WIDTH:0]   num_words;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  busy;
  logic                  done;

  // master: requester plus BRAM side; slave: the transmitter
  modport master (
    output start, num_words, rd_data,
    input  rd_en, rd_addr, busy, done
  );

  modport slave (
    input  start, num_words, rd_data,
    output rd_en, rd_addr, busy, done
  );
endinterface

// File: rtl/result_uart_tx.sv
// Reads num_words result words from BRAM and sends each as 8N1 bytes, LSB byte first.
module result_uart_tx #(
  parameter int unsigned CLOCK_FREQ = 50_000_000,
  parameter int unsigned BAUD       = 115200,
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  result_uart_tx_if.slave  bus,
  output logic             tx
);
  localparam int unsigned CLKS_PER_BIT = CLOCK_FREQ / BAUD;
  localparam int unsigned BYTES        = DATA_WIDTH / 8;
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int unsigned BYTE_W       = (BYTES > 1) ? $clog2(BYTES) : 1;

  localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BYTE_W-1:0]   BYTE_LAST = BYTE_W'(BYTES - 1);
  localparam logic [ADDR_WIDTH:0] IDX_ONE   = (ADDR_WIDTH+1)'(1);

  typedef enum logic [2:0] {
    IDLE, FETCH, WAIT, START_BIT, DATA_BITS, STOP_BIT, DONE
  } state_t;

  state_t                state;
  logic [CNT_W-1:0]      clk_cnt;
  logic [2:0]            bit_idx;
  logic [BYTE_W-1:0]     byte_idx;
  logic [ADDR_WIDTH:0]   word_idx;
  logic [ADDR_WIDTH:0]   word_cnt;
  logic [ADDR_WIDTH:0]   next_idx;
  logic [DATA_WIDTH-1:0] shift;

  always_comb next_idx = word_idx + IDX_ONE;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      clk_cnt     <= '0;
      bit_idx     <= '0;
      byte_idx    <= '0;
      word_idx    <= '0;
      word_cnt    <= '0;
      shift       <= '0;
      tx          <= 1'b1;
      bus.busy    <= 1'b0;
      bus.done    <= 1'b0;
      bus.rd_en   <= 1'b0;
      bus.rd_addr <= '0;
    end else begin
      bus.rd_en <= 1'b0;
      bus.done  <= 1'b0;
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (bus.start) begin
            if (bus.num_words != '0) begin
              word_cnt    <= bus.num_words;
              word_idx    <= '0;
              bus.rd_en   <= 1'b1;
              bus.rd_addr <= '0;
              bus.busy    <= 1'b1;
              state       <= FETCH;
            end else begin
              bus.done <= 1'b1;
              state    <= DONE;
            end
          end
        end
        FETCH: state <= WAIT;
        WAIT: begin
          shift    <= bus.rd_data;
          byte_idx <= '0;
          bit_idx  <= '0;
          clk_cnt  <= '0;
          tx       <= 1'b0;
          state    <= START_BIT;
        end
        START_BIT: begin
          if (clk_cnt == CNT_LAST) begin
            clk_cnt <= '0;
            tx      <= shift[0];
            state   <= DATA_BITS;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        // Shifting the whole word right leaves the next byte in [7:0] after 8 bits.
        DATA_BITS: begin
          if (clk_cnt == CNT_LAST) begin
            clk_cnt <= '0;
            shift   <= shift >> 1;
            if (bit_idx == 3'd7) begin
              bit_idx <= '0;
              tx      <= 1'b1;
              state   <= STOP_BIT;
            end else begin
              bit_idx <= bit_idx + 1'b1;
              tx      <= shift[1];
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        STOP_BIT: begin
          if (clk_cnt == CNT_LAST) begin
            clk_cnt <= '0;
            if (byte_idx != BYTE_LAST) begin
              byte_idx <= byte_idx + 1'b1;
              tx       <= 1'b0;
              state    <= START_BIT;
            end else if (next_idx != word_cnt) begin
              word_idx    <= next_idx;
              bus.rd_en   <= 1'b1;
              bus.rd_addr <= next_idx[ADDR_WIDTH-1:0];
              state       <= FETCH;
            end else begin
              bus.busy <= 1'b0;
              bus.done <= 1'b1;
              state    <= DONE;
            end
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_result_uart_tx.sv
// Self-checking bench for result_uart_tx: vector table, random transfers and reset/start corner cases.
module tb_result_uart_tx;
    localparam int CLOCK_FREQ = 1_000_000;
    localparam int BAUD       = 250_000;
    localparam int AW         = 4;
    localparam int DW         = 16;
    localparam int CPB        = CLOCK_FREQ / BAUD;
    localparam int BYTES      = DW / 8;
    localparam int FRAME      = 10 * CPB;
    localparam int WORD_P     = BYTES * FRAME + 2;

    logic clk;
    logic rst;
    logic tx;
    logic [DW-1:0] mem [0:(1<<AW)-1];

    int checks = 0;
    int errors = 0;

    result_uart_tx_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    result_uart_tx #(
        .CLOCK_FREQ(CLOCK_FREQ),
        .BAUD(BAUD),
        .ADDR_WIDTH(AW),
        .DATA_WIDTH(DW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .tx(tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // BRAM model, one-cycle read latency
    always @(posedge clk) if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr];

    typedef struct {
        int w;
        int hold;
        int memsel;
        int exp_done;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int done_cycle(input int w);
        if (w == 0) return 1;
        return 2 + w * BYTES * FRAME + (w - 1) * 2 + 1;
    endfunction

    function automatic bit exp_tx(input int c, input int w);
        int t, wi, r, b, bp;
        logic [DW-1:0] word;
        if (w == 0 || c < 3) return 1'b1;
        t  = c - 3;
        wi = t / WORD_P;
        r  = t % WORD_P;
        if (wi >= w || r >= BYTES * FRAME) return 1'b1;
        b    = r / FRAME;
        bp   = (r % FRAME) / CPB;
        word = mem[wi];
        if (bp == 0) return 1'b0;
        if (bp == 9) return 1'b1;
        return word[8*b + bp - 1];
    endfunction

    task automatic fill_mem(input int memsel);
        for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
        if (memsel == 1) mem[0] = 16'hA53C;
        if (memsel == 2) begin
            mem[0] = 16'h0102;
            mem[1] = 16'h0304;
            mem[2] = 16'hFFFF;
        end
    endtask

    task automatic run_xfer(input int w, input int hold, input int exp_done, input string tag);
        int tx_log[$];
        int busy_log[$];
        int ra_cyc[$];
        int ra_addr[$];
        int done_cycs[$];
        int got_bytes[$];
        int exp_bytes[$];
        int budget, nbad, first_bad, i, n, bv;
        logic [DW-1:0] word;

        @(negedge clk);
        bus.start     = 1'b1;
        bus.num_words = (AW+1)'(w);
        budget = exp_done + 20;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (c >= hold) bus.start = 1'b0;
            tx_log.push_back(int'(tx));
            busy_log.push_back(int'(bus.busy));
            if (bus.rd_en) begin
                ra_cyc.push_back(c);
                ra_addr.push_back(int'(bus.rd_addr));
            end
            if (bus.done) done_cycs.push_back(c);
            if (done_cycs.size() > 0 && c >= done_cycs[0] + 4) break;
        end
        bus.start = 1'b0;

        chk({tag, " done_pulses"}, done_cycs.size(), 1);
        chk({tag, " done_cycle"}, (done_cycs.size() > 0) ? done_cycs[0] : -1, exp_done);
        chk({tag, " rd_count"}, ra_cyc.size(), w);
        for (int k = 0; k < w && k < ra_cyc.size(); k++)
            chk($sformatf("%s rd[%0d] cyc/addr", tag, k),
                (64'(ra_cyc[k]) << 16) | 64'(ra_addr[k]),
                (64'(1 + k * WORD_P) << 16) | 64'(k));

        nbad = 0; first_bad = 0;
        for (int c = 1; c <= exp_done && c <= tx_log.size(); c++)
            if (tx_log[c-1] != int'(exp_tx(c, w))) begin
                if (nbad == 0) first_bad = c;
                nbad++;
            end
        checks++;
        if (nbad != 0 || tx_log.size() < exp_done) begin
            errors++;
            $display("FAIL %s tx_wave: %0d wrong cycles, first at cycle %0d got %0d expected %0d",
                     tag, nbad, first_bad, (first_bad > 0) ? tx_log[first_bad-1] : -1,
                     (first_bad > 0) ? int'(exp_tx(first_bad, w)) : -1);
        end

        nbad = 0;
        for (int c = 1; c <= exp_done && c <= busy_log.size(); c++)
            if (busy_log[c-1] != ((w != 0 && c < exp_done) ? 1 : 0)) nbad++;
        chk({tag, " busy_bad_cycles"}, nbad, 0);

        // independent mid-bit UART decode of the captured line
        n = tx_log.size();
        i = 1;
        while (i < n) begin
            if (tx_log[i] == 0 && tx_log[i-1] == 1) begin
                if (i + CPB/2 + 8*CPB >= n) break;
                bv = 0;
                for (int k = 1; k <= 8; k++) bv |= tx_log[i + CPB/2 + k*CPB] << (k - 1);
                got_bytes.push_back(bv);
                i += FRAME;
            end else begin
                i++;
            end
        end
        for (int wi = 0; wi < w; wi++) begin
            word = mem[wi];
            for (int b = 0; b < BYTES; b++) exp_bytes.push_back(int'((word >> (8*b)) & 'hFF));
        end
        chk({tag, " byte_count"}, got_bytes.size(), exp_bytes.size());
        for (int k = 0; k < exp_bytes.size() && k < got_bytes.size(); k++)
            chk($sformatf("%s byte[%0d]", tag, k), got_bytes[k], exp_bytes[k]);
    endtask

    vec_t vecs[5];
    int ones, dn, rdn, w;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{w: 1,  hold: 1,   memsel: 1, exp_done: 83};
        vecs[1] = '{w: 3,  hold: 1,   memsel: 2, exp_done: 247};
        vecs[2] = '{w: 0,  hold: 1,   memsel: 0, exp_done: 1};
        vecs[3] = '{w: 2,  hold: 100, memsel: 0, exp_done: 165};
        vecs[4] = '{w: 16, hold: 1,   memsel: 0, exp_done: 1313};

        rst = 1'b0;
        bus.start = 1'b0;
        bus.num_words = '0;
        bus.rd_data = '0;

        // asynchronous reset between clock edges
        #3 rst = 1'b1;
        #1;
        chk("reset tx", tx, 1);
        chk("reset busy", bus.busy, 0);
        chk("reset done", bus.done, 0);
        chk("reset rd_en", bus.rd_en, 0);
        chk("reset rd_addr", bus.rd_addr, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 5; v++) begin
            fill_mem(vecs[v].memsel);
            run_xfer(vecs[v].w, vecs[v].hold, vecs[v].exp_done, $sformatf("vec%0d", v));
        end

        for (int r = 0; r < 4; r++) begin
            fill_mem(0);
            w = $urandom_range(1, 4);
            run_xfer(w, $urandom_range(1, 20), done_cycle(w), $sformatf("rand%0d", r));
        end

        // start in the DONE cycle is ignored, accepted in the following IDLE cycle
        fill_mem(0);
        @(negedge clk);
        bus.start = 1'b1;
        bus.num_words = '0;
        @(negedge clk);
        chk("zero done at N+1", bus.done, 1);
        bus.num_words = (AW+1)'(1);
        @(negedge clk);
        chk("done-cycle start ignored rd_en", bus.rd_en, 0);
        chk("done-cycle start ignored busy", bus.busy, 0);
        @(negedge clk);
        bus.start = 1'b0;
        chk("idle start accepted rd_en", bus.rd_en, 1);
        chk("idle start accepted busy", bus.busy, 1);
        dn = 0;
        for (int c = 0; c < 200 && dn == 0; c++) begin
            @(negedge clk);
            if (bus.done) dn = 1;
        end
        chk("idle start completes", dn, 1);
        repeat (3) @(negedge clk);

        // reset during data bits of the second byte aborts the transfer
        fill_mem(0);
        mem[0] = 16'h00FF;
        @(negedge clk);
        bus.start = 1'b1;
        bus.num_words = (AW+1)'(2);
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
        chk("pre-abort tx low", tx, 0);
        #2 rst = 1'b1;
        #1;
        chk("abort tx", tx, 1);
        chk("abort busy", bus.busy, 0);
        chk("abort done", bus.done, 0);
        @(negedge clk);
        rst = 1'b0;
        ones = 0; dn = 0; rdn = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            ones += int'(tx);
            dn   += int'(bus.done);
            rdn  += int'(bus.rd_en);
        end
        chk("post-abort tx idle cycles", ones, 100);
        chk("post-abort done pulses", dn, 0);
        chk("post-abort rd_en cycles", rdn, 0);
        mem[0] = 16'h5AC3;
        run_xfer(1, 1, 83, "post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/result_uart_tx.md
# result_uart_tx

Readback path for the accelerator. On a start pulse it reads a block of DATA_WIDTH-bit words from a result BRAM through a synchronous read port and serialises each word onto a UART line as 8N1 bytes, least-significant byte first. It is the transmit-side counterpart of the host-to-FPGA UART/command path: it shares the same CLOCK_FREQ/BAUD parameters and the same bram_buffer read interface, so the host can retrieve matmul outputs over the same serial link.

## Interface
- CLOCK_FREQ, 50_000_000, system clock in Hz
- BAUD, 115200, line rate; CLKS_PER_BIT = CLOCK_FREQ / BAUD (integer division, must be ≥ 2)
- ADDR_WIDTH, 10, result BRAM address width
- DATA_WIDTH, 16, word width; must be a nonzero multiple of 8; BYTES = DATA_WIDTH / 8

- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  single-cycle request; sampled only when busy = 0
- num_words  input  ADDR_WIDTH+1  words to send, latched on accepted start; legal range 0 .. 2^ADDR_WIDTH
- rd_en  output  1  BRAM read enable
- rd_addr  output  ADDR_WIDTH  BRAM read address
- rd_data  input  DATA_WIDTH  BRAM read data; valid the cycle after rd_en
- tx  output  1  UART line, idle high
- busy  output  1  high from the cycle after an accepted start through the last stop bit
- done  output  1  one-cycle pulse at the end of a transfer

## Operation
- Reset values: tx = 1, busy = 0, done = 0, rd_en = 0, rd_addr = 0. All internal counters are 0; state is IDLE.
- States: IDLE, FETCH, WAIT, START_BIT, DATA_BITS, STOP_BIT, DONE.
- IDLE: tx = 1. start = 1 with num_words ≠ 0 latches the count, clears the word index, and moves to FETCH. start = 1 with num_words = 0 moves to DONE with no read and no tx activity.
- FETCH (1 cycle): rd_en = 1, rd_addr = word index → WAIT.
- WAIT (1 cycle): capture rd_data into the shift word and set byte index = 0 → START_BIT.
- START_BIT: tx = 0 for CLKS_PER_BIT cycles → DATA_BITS.
- DATA_BITS: 8 bits, bit 0 first, each held for CLKS_PER_BIT cycles. Byte k = word[8k+7:8k].
- STOP_BIT: tx = 1 for CLKS_PER_BIT cycles, then:
  - If more bytes remain in the word: move to START_BIT with no gap.
  - Else, if more words remain: increment the word index and move to FETCH.
  - Else: move to DONE.
- DONE (1 cycle): done = 1, busy = 0 → IDLE.
- start while busy is ignored. rd_en is high only in FETCH. rd_addr holds its last value otherwise.
- Addresses issued are 0 .. num_words−1 and never wrap. The word index counter is ADDR_WIDTH+1 bits wide.
- Reset mid-transfer aborts immediately: tx = 1, no done pulse, the partial byte is discarded.

## Timing
- Start accepted at rising edge N:
  - FETCH occupies cycle N+1 (rd_en = 1, rd_addr = 0).
  - WAIT occupies cycle N+2.
  - tx falls at the start of cycle N+3.
- Each byte lasts exactly 10 × CLKS_PER_BIT cycles.
- Bytes within one word are back-to-back.
- Between words, tx stays high for exactly 2 extra cycles (FETCH + WAIT) after the stop bit.
- done is asserted in the cycle immediately after the final stop-bit cycle.
- Total cycles from the accepted edge to the done cycle = 2 + W·BYTES·10·CLKS_PER_BIT + (W−1)·2 + 1, for W ≥ 1 words.
- num_words = 0: done is asserted in cycle N+1.
- busy = 1 from cycle N+1 through the last stop-bit cycle.
- start arriving in the DONE cycle is ignored. It is accepted the following cycle in IDLE.

## Test plan
Bench parameters: CLOCK_FREQ = 1_000_000, BAUD = 250_000 (CLKS_PER_BIT = 4), DATA_WIDTH = 16, BRAM model with 1-cycle read latency.

- Reset: assert rst asynchronously mid-clock → tx = 1, busy = 0, done = 0, rd_en = 0 with no clock edge required.
- Single word: mem[0] = 0xA53C, start with num_words = 1 → rd_en with rd_addr = 0 at N+1; tx decodes bytes 0x3C then 0xA5, 80 cycles of frame; done pulse at cycle N+83.
- Multi-word: mem[0..2] = 0x0102, 0x0304, 0xFFFF, num_words = 3 → byte stream 02 01 04 03 FF FF; rd_addr sequence 0, 1, 2; exactly 2 high cycles between words; done at N+247.
- Zero count: num_words = 0 → done at N+1, rd_en never high, tx constant 1.
- start held high for 100 cycles during a 2-word transfer → exactly one transfer, one done pulse, 4 bytes sent.
- rst pulsed during the DATA_BITS of the second byte → tx = 1 immediately, no done; a fresh start with num_words = 1 then sends a complete correct frame.
